// File: rtl/clk_ratio_detector.sv
// -----------------------------------------------------------------------------
// clk_ratio_detector
//
// Measures the period of an asynchronous divided clock (i_div_clk) in cycles of
// the reference clock (i_ref_clk). The input is passed through a two-flop
// synchronizer and an edge-detect flop. An IDLE -> ARM -> MEAS state machine
// then counts reference cycles between successive detected rising edges.
//
// Ports
//   i_ref_clk   : reference clock; all logic runs on its rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_en        : synchronous detection enable
//   i_div_clk   : divided clock under measurement (asynchronous)
//   o_ratio     : last measured period, in i_ref_clk cycles
//   o_ratio_vld : one-cycle pulse when o_ratio updates
//   o_locked    : two consecutive equal periods measured
//   o_err       : sticky timeout flag (cleared by reset or i_en low)
//   o_high_cnt  : high-phase length of the last measured period
//
// Build option
//   CLK_RATIO_DUTY_EN : when defined, a high-phase counter is built and its
//                       value is published on o_high_cnt with every
//                       o_ratio_vld pulse; otherwise o_high_cnt is tied to 0.
// -----------------------------------------------------------------------------
module clk_ratio_detector #(
  parameter int unsigned RATIO_WIDTH = 5
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_div_clk,
  output logic [RATIO_WIDTH-1:0] o_ratio,
  output logic                   o_ratio_vld,
  output logic                   o_locked,
  output logic                   o_err,
  output logic [RATIO_WIDTH-1:0] o_high_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [RATIO_WIDTH-1:0] CNT_ONE = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q,  edge_d;
  logic rise;

  always_comb begin
    sync1_d = i_div_clk;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
  end

  // Synchronized level is high and was low one cycle earlier.
  assign rise = sync2_q & ~edge_q;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement state machine and period counter
  // ---------------------------------------------------------------------------
  state_t                 state_q,   state_d;
  logic [RATIO_WIDTH-1:0] cnt_q,     cnt_d;
  logic [RATIO_WIDTH-1:0] ratio_q,   ratio_d;
  logic                   vld_q,     vld_d;
  logic                   locked_q,  locked_d;
  logic                   err_q,     err_d;
  // Set once this run has produced a measurement, so lock is only judged
  // against a period measured since the last enable, reset or timeout.
  logic                   prev_ok_q, prev_ok_d;
  // Qualifies a detected edge that completes a measurement this cycle.
  logic                   meas_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ratio_d   = ratio_q;
    vld_d     = 1'b0;
    locked_d  = locked_q;
    err_d     = err_q;
    prev_ok_d = prev_ok_q;
    meas_done = 1'b0;

    if (!i_en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      locked_d  = 1'b0;
      err_d     = 1'b0;
      prev_ok_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end

        ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEAS;
          end
        end

        MEAS: begin
          // An edge takes priority over a simultaneous timeout, so a period of
          // exactly CNT_MAX cycles is still reported.
          if (rise) begin
            meas_done = 1'b1;
            ratio_d   = cnt_q;
            vld_d     = 1'b1;
            locked_d  = prev_ok_q && (cnt_q == ratio_q);
            prev_ok_d = 1'b1;
            cnt_d     = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            err_d     = 1'b1;
            locked_d  = 1'b0;
            prev_ok_d = 1'b0;
            cnt_d     = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ratio_q   <= '0;
      vld_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      prev_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      vld_q     <= vld_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      prev_ok_q <= prev_ok_d;
    end
  end

  assign o_ratio     = ratio_q;
  assign o_ratio_vld = vld_q;
  assign o_locked    = locked_q;
  assign o_err       = err_q;

  // ---------------------------------------------------------------------------
  // Optional high-phase measurement
  // ---------------------------------------------------------------------------
`ifdef CLK_RATIO_DUTY_EN
  logic [RATIO_WIDTH-1:0] hi_q,   hi_d;
  logic [RATIO_WIDTH-1:0] high_q, high_d;

  // Counts synchronized-high cycles starting with 1 on each detected rising
  // edge; the running value is captured alongside o_ratio.
  always_comb begin
    hi_d   = hi_q;
    high_d = high_q;
    if (!i_en || (state_q == IDLE)) begin
      hi_d = '0;
    end else if (rise) begin
      hi_d = CNT_ONE;
      if (meas_done) begin
        high_d = hi_q;
      end
    end else if (sync2_q && (hi_q != CNT_MAX)) begin
      hi_d = hi_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q   <= '0;
      high_q <= '0;
    end else begin
      hi_q   <= hi_d;
      high_q <= high_d;
    end
  end

  assign o_high_cnt = high_q;
`else
  assign o_high_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_ratio_detector.sv
module tb_clk_ratio_detector;

  localparam int W   = 5;
  localparam int MAX = 31;
`ifdef CLK_RATIO_DUTY_EN
  localparam int HI_EN = 1;
`else
  localparam int HI_EN = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         div;
  logic [W-1:0] o_ratio;
  logic         o_ratio_vld;
  logic         o_locked;
  logic         o_err;
  logic [W-1:0] o_high_cnt;

  clk_ratio_detector #(.RATIO_WIDTH(W)) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_div_clk  (div),
    .o_ratio    (o_ratio),
    .o_ratio_vld(o_ratio_vld),
    .o_locked   (o_locked),
    .o_err      (o_err),
    .o_high_cnt (o_high_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ratio;
    int locked;
    int high;
    int gap;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (drive-cycle indexed)
  int cyc_drv    = 0;
  int armed_m    = 0;
  int last_rise  = 0;
  int prev_ok    = 0;
  int prev_r     = 0;
  int high_m     = 0;
  int have_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    armed_m    = 0;
    prev_ok    = 0;
    have_pulse = 0;
  endtask

  task automatic model_rise();
    exp_t e;
    int   gap;
    if (armed_m == 0) begin
      armed_m    = 1;
      have_pulse = 0;
    end else begin
      gap = cyc_drv - last_rise;
      if (gap > MAX) begin
        // timed out in between: this edge only re-arms
        prev_ok    = 0;
        have_pulse = 0;
      end else begin
        e.ratio  = gap;
        e.locked = (prev_ok != 0 && gap == prev_r) ? 1 : 0;
        e.high   = (HI_EN != 0) ? high_m : 0;
        e.gap    = (have_pulse != 0) ? gap : 0;
        exp_q.push_back(e);
        prev_ok    = 1;
        prev_r     = gap;
        have_pulse = 1;
      end
    end
    last_rise = cyc_drv;
    high_m    = 1;
  endtask

  task automatic drive_bit(input logic v);
    logic was;
    @(posedge clk);
    #1;
    was = div;
    div = v;
    cyc_drv++;
    if (v && !was) model_rise();
    else if (v && high_m < MAX) high_m++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) drive_bit(1'b1);
      for (int i = 0; i < l; i++) drive_bit(1'b0);
    end
  endtask

  // Scoreboard monitor: every o_ratio_vld pulse pops one expected measurement
  int cyc_mon  = 0;
  int last_vld = 0;
  always @(posedge clk) cyc_mon++;

  always @(negedge clk) begin
    exp_t e;
    if (o_ratio_vld === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_vld observed=%0d expected=%0d", o_ratio, 0);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("vld_ratio",  32'(o_ratio),    e.ratio);
        chk("vld_locked", 32'(o_locked),   e.locked);
        chk("vld_high",   32'(o_high_cnt), e.high);
        if (e.gap != 0) chk("vld_spacing", cyc_mon - last_vld, e.gap);
      end
      last_vld = cyc_mon;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    div   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ratio",  32'(o_ratio),     0);
    chk("rst_vld",    32'(o_ratio_vld), 0);
    chk("rst_locked", 32'(o_locked),    0);
    chk("rst_err",    32'(o_err),       0);
    chk("rst_high",   32'(o_high_cnt),  0);

    // Ratio 4, 50% duty
    rst_n = 1'b1;
    idle(2);
    en = 1'b1;
    idle(4);
    wave(2, 2, 5);
    chk("r4_ratio",  32'(o_ratio),    4);
    chk("r4_locked", 32'(o_locked),   1);
    chk("r4_err",    32'(o_err),      0);
    chk("r4_high",   32'(o_high_cnt), 2 * HI_EN);

    // Switch to ratio 6 while locked
    wave(3, 3, 4);
    chk("r6_ratio",  32'(o_ratio),  6);
    chk("r6_locked", 32'(o_locked), 1);

    // Longest measurable period: edge coincides with counter at max
    wave(10, 21, 3);
    chk("r31_ratio",  32'(o_ratio),  31);
    chk("r31_err",    32'(o_err),    0);
    chk("r31_locked", 32'(o_locked), 1);

    // Lock at 4, then hold input low until timeout
    wave(2, 2, 3);
    chk("pre_to_locked", 32'(o_locked), 1);
    while (cyc_drv < last_rise + 30) drive_bit(1'b0);
    chk("to_early_err",    32'(o_err),    0);
    chk("to_early_locked", 32'(o_locked), 1);
    while (cyc_drv < last_rise + 40) drive_bit(1'b0);
    chk("to_err",    32'(o_err),    1);
    chk("to_locked", 32'(o_locked), 0);
    chk("to_ratio",  32'(o_ratio),  4);

    // Relock after timeout: error stays sticky
    wave(2, 2, 3);
    chk("relock_locked", 32'(o_locked), 1);
    chk("sticky_err",    32'(o_err),    1);

    // Drop enable mid-period
    idle(1);
    en = 1'b0;
    model_clear();
    idle(4);
    chk("dis_err",    32'(o_err),       0);
    chk("dis_locked", 32'(o_locked),    0);
    chk("dis_vld",    32'(o_ratio_vld), 0);
    chk("dis_ratio",  32'(o_ratio),     4);
    chk("dis_high",   32'(o_high_cnt),  2 * HI_EN);
    en = 1'b1;
    idle(3);
    wave(2, 2, 3);
    chk("reen_locked", 32'(o_locked), 1);

    // Ratio 5: high 2, low 3
    wave(2, 3, 4);
    chk("r5_ratio",  32'(o_ratio),    5);
    chk("r5_locked", 32'(o_locked),   1);
    chk("r5_high",   32'(o_high_cnt), 2 * HI_EN);

    // Reset pulse mid-measurement
    idle(2);
    chk("pre_rst_queue", exp_q.size(), 0);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("mrst_ratio",  32'(o_ratio),     0);
    chk("mrst_vld",    32'(o_ratio_vld), 0);
    chk("mrst_locked", 32'(o_locked),    0);
    chk("mrst_err",    32'(o_err),       0);
    chk("mrst_high",   32'(o_high_cnt),  0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    wave(2, 3, 3);
    chk("post_rst_locked", 32'(o_locked), 1);
    chk("post_rst_ratio",  32'(o_ratio),  5);

    idle(6);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
